register_file_mp: RTL and testbench

- Parametrised successor to the single-write, two-read MIPS register file.
- Provides NUM_RD combinational read ports and two write ports (ALU writeback and load writeback) with a fixed write priority.
- Adds write-first bypass, a hardwired-zero register 0, and a per-register busy scoreboard, so the hazard unit can stall on pending loads without extra tracking.
- Sits in the decode stage; writeback drives the write ports.

---
 rtl/mips_rf_pkg.sv | 16 +
 rtl/register_file_mp_if.sv | 34 +++
 rtl/rf_scoreboard.sv | 53 +++++
 rtl/register_file_mp.sv | 86 ++++++++
 tb/tb_register_file_mp.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_rf_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   REG_ZERO                : index of the hardwired-zero register
//   field_lsb()             : LSB of field k in a flattened per-port vector
package mips_rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;

  // Port k of a flattened vector occupies [k*w +: w].
  function automatic int unsigned field_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus between decode/writeback and the register file.
//   A_RD/RD/RD_BUSY : flattened read ports (address, data, busy)
//   WE0/A0/WD0      : ALU writeback port
//   WE1/A1/WD1      : load writeback port (wins on an address clash)
//   BSET/BSET_A     : mark a register busy when a load issues
interface register_file_mp_if
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] A_RD;
  logic [NUM_RD*DATA_W-1:0] RD;
  logic [NUM_RD-1:0]        RD_BUSY;
  logic                     WE0;
  logic [ADDR_W-1:0]        A0;
  logic [DATA_W-1:0]        WD0;
  logic                     WE1;
  logic [ADDR_W-1:0]        A1;
  logic [DATA_W-1:0]        WD1;
  logic                     BSET;
  logic [ADDR_W-1:0]        BSET_A;

  modport master (
    output A_RD, WE0, A0, WD0, WE1, A1, WD1, BSET, BSET_A,
    input  RD, RD_BUSY
  );

  modport slave (
    input  A_RD, WE0, A0, WD0, WE1, A1, WD1, BSET, BSET_A,
    output RD, RD_BUSY
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for pending load producers.
//   clk, reset      : clock, synchronous active-low reset
//   we0/a0, we1/a1  : writes clear the busy bit of their target
//   bset/bset_a     : set a busy bit (set beats a same-cycle clear)
//   rd_addr         : per-port lookup address
//   busy_c          : combinational busy, masked by a same-cycle write hit
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [ADDR_W-1:0] a0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] a1,
  input  logic              bset,
  input  logic [ADDR_W-1:0] bset_a,
  input  logic [ADDR_W-1:0] rd_addr [NUM_RD],
  output logic [NUM_RD-1:0] busy_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clears first, then set, so the newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (we0) busy_d[a0] = 1'b0;
    if (we1) busy_d[a1] = 1'b0;
    if (bset && !(ZERO_REG && bset_a == ADDR_W'(REG_ZERO))) busy_d[bset_a] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A register written this cycle is served by the bypass, so not busy.
  always_comb begin
    busy_c = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      busy_c[k] = busy_q[rd_addr[k]] &&
                  !((we1 && a1 == rd_addr[k]) || (we0 && a0 == rd_addr[k]));
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports
// (port 1 wins on a clash), write-first bypass, optional zero register and
// a busy scoreboard for load hazards.
//   clk, reset : clock, synchronous active-low reset
//   bus        : register_file_mp_if slave (read/write/busy-set signals)
module register_file_mp
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  register_file_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  generate
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("register_file_mp: NUM_RD must be in 1..4");
    end
  endgenerate

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic              wr0_ok;
  logic              wr1_ok;

  // Port 1 is applied last so it overrides port 0 on the same address.
  always_comb begin
    wr0_ok = bus.WE0 && !(ZERO_REG && bus.A0 == ADDR_W'(REG_ZERO));
    wr1_ok = bus.WE1 && !(ZERO_REG && bus.A1 == ADDR_W'(REG_ZERO));
    regs_d = regs_q;
    if (wr0_ok) regs_d[bus.A0] = bus.WD0;
    if (wr1_ok) regs_d[bus.A1] = bus.WD1;
  end

  always_ff @(posedge clk) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // Unflatten read addresses.
  always_comb begin
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_addr[k] = bus.A_RD[field_lsb(k, ADDR_W) +: ADDR_W];
    end
  end

  // Read mux: zero register, then port 1 bypass, then port 0 bypass, then storage.
  always_comb begin
    bus.RD = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (ZERO_REG && rd_addr[k] == ADDR_W'(REG_ZERO))
        bus.RD[field_lsb(k, DATA_W) +: DATA_W] = '0;
      else if (bus.WE1 && bus.A1 == rd_addr[k])
        bus.RD[field_lsb(k, DATA_W) +: DATA_W] = bus.WD1;
      else if (bus.WE0 && bus.A0 == rd_addr[k])
        bus.RD[field_lsb(k, DATA_W) +: DATA_W] = bus.WD0;
      else
        bus.RD[field_lsb(k, DATA_W) +: DATA_W] = regs_q[rd_addr[k]];
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .we0     (bus.WE0),
    .a0      (bus.A0),
    .we1     (bus.WE1),
    .a1      (bus.A1),
    .bset    (bus.BSET),
    .bset_a  (bus.BSET_A),
    .rd_addr (rd_addr),
    .busy_c  (bus.RD_BUSY)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a 2-read-port instance for the main
// sequence and a 4-read-port instance for port slicing.
module tb_register_file_mp;

  logic clk;
  logic reset;

  register_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) b2 ();
  register_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) b4 ();

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );
  register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1'b1)) dut4 (
    .clk(clk), .reset(reset), .bus(b4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    total_cnt++;
    if (exp_q.size() == 0) begin
      fail_cnt++;
      $error("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h required %h", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd2(input int k);
    return b2.RD[k*32 +: 32];
  endfunction

  function automatic logic [31:0] bz2(input int k);
    return 32'(b2.RD_BUSY[k]);
  endfunction

  function automatic logic [31:0] rd4(input int k);
    return b4.RD[k*32 +: 32];
  endfunction

  task automatic idle2();
    b2.WE0 = 1'b0; b2.A0 = '0; b2.WD0 = '0;
    b2.WE1 = 1'b0; b2.A1 = '0; b2.WD1 = '0;
    b2.BSET = 1'b0; b2.BSET_A = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle2();
    b2.A_RD = '0;
    b4.A_RD = '0;
    b4.WE0 = 1'b0; b4.A0 = '0; b4.WD0 = '0;
    b4.WE1 = 1'b0; b4.A1 = '0; b4.WD1 = '0;
    b4.BSET = 1'b0; b4.BSET_A = '0;

    // Reset: prior write and a write/busy-set during the reset edge are lost.
    b2.WE0 = 1'b1; b2.A0 = 5'd5; b2.WD0 = 32'h0000_1234;
    step();
    reset = 1'b0;
    b2.WE0 = 1'b1; b2.A0 = 5'd5; b2.WD0 = 32'h0000_BAD0;
    b2.BSET = 1'b1; b2.BSET_A = 5'd5;
    step();
    reset = 1'b1;
    idle2();
    for (int i = 0; i < 32; i++) begin
      b2.A_RD = {5'(i), 5'(i)};
      push($sformatf("reset_rd0_a%0d", i), 32'h0);
      push($sformatf("reset_rd1_a%0d", i), 32'h0);
      push($sformatf("reset_busy_a%0d", i), 32'h0);
      #1;
      chk(rd2(0));
      chk(rd2(1));
      chk(32'(b2.RD_BUSY));
    end
    step();

    // Write priority: port 1 wins, visible by bypass then from storage.
    b2.WE0 = 1'b1; b2.A0 = 5'd7; b2.WD0 = 32'hAAAA_0000;
    b2.WE1 = 1'b1; b2.A1 = 5'd7; b2.WD1 = 32'h5555_FFFF;
    b2.A_RD = {5'd0, 5'd7};
    push("prio_bypass", 32'h5555_FFFF);
    #1; chk(rd2(0));
    step();
    idle2();
    push("prio_store1", 32'h5555_FFFF);
    #1; chk(rd2(0));
    step();
    push("prio_store2", 32'h5555_FFFF);
    #1; chk(rd2(0));

    // Port 0 bypass on read port 1, then storage.
    step();
    b2.WE0 = 1'b1; b2.A0 = 5'd9; b2.WD0 = 32'hDEAD_BEEF;
    b2.A_RD = {5'd9, 5'd7};
    push("byp_rd1", 32'hDEAD_BEEF);
    push("byp_rd0_other", 32'h5555_FFFF);
    #1; chk(rd2(1)); chk(rd2(0));
    step();
    idle2();
    push("byp_store_rd1", 32'hDEAD_BEEF);
    #1; chk(rd2(1));

    // Zero register ignores writes and busy-set.
    step();
    b2.WE1 = 1'b1; b2.A1 = 5'd0; b2.WD1 = 32'hFFFF_FFFF;
    b2.BSET = 1'b1; b2.BSET_A = 5'd0;
    b2.A_RD = {5'd0, 5'd0};
    push("zero_same_rd", 32'h0);
    push("zero_same_busy", 32'h0);
    #1; chk(rd2(0)); chk(bz2(0));
    step();
    idle2();
    push("zero_after_rd", 32'h0);
    push("zero_after_busy", 32'h0);
    #1; chk(rd2(0)); chk(bz2(0));

    // Scoreboard set, bypass-masked clear, and set beating clear.
    step();
    b2.BSET = 1'b1; b2.BSET_A = 5'd12;
    b2.A_RD = {5'd13, 5'd12};
    push("sb_set_same_cycle", 32'h0);
    #1; chk(bz2(0));
    step();
    idle2();
    push("sb_busy_next", 32'h1);
    push("sb_other_not_busy", 32'h0);
    #1; chk(bz2(0)); chk(bz2(1));
    step();
    b2.WE1 = 1'b1; b2.A1 = 5'd12; b2.WD1 = 32'h0000_0042;
    push("sb_clear_busy", 32'h0);
    push("sb_clear_rd", 32'h0000_0042);
    #1; chk(bz2(0)); chk(rd2(0));
    step();
    idle2();
    push("sb_cleared_busy", 32'h0);
    push("sb_cleared_rd", 32'h0000_0042);
    #1; chk(bz2(0)); chk(rd2(0));
    step();
    b2.BSET = 1'b1; b2.BSET_A = 5'd12;
    b2.WE0 = 1'b1; b2.A0 = 5'd12; b2.WD0 = 32'h0000_0077;
    push("sb_setclr_same", 32'h0);
    #1; chk(bz2(0));
    step();
    idle2();
    push("sb_set_wins", 32'h1);
    push("sb_set_wins_rd", 32'h0000_0077);
    #1; chk(bz2(0)); chk(rd2(0));

    // Reset in the middle of pending state discards everything.
    step();
    b2.WE0 = 1'b1; b2.A0 = 5'd20; b2.WD0 = 32'h0000_CAFE;
    step();
    reset = 1'b0;
    b2.WE0 = 1'b0;
    b2.WE1 = 1'b1; b2.A1 = 5'd20; b2.WD1 = 32'h0000_F00D;
    b2.BSET = 1'b1; b2.BSET_A = 5'd21;
    step();
    reset = 1'b1;
    idle2();
    b2.A_RD = {5'd12, 5'd20};
    push("mid_reset_rd20", 32'h0);
    push("mid_reset_rd12", 32'h0);
    push("mid_reset_busy", 32'h0);
    #1; chk(rd2(0)); chk(rd2(1)); chk(32'(b2.RD_BUSY));
    b2.A_RD = {5'd9, 5'd21};
    push("mid_reset_busy21", 32'h0);
    push("mid_reset_rd9", 32'h0);
    #1; chk(bz2(0)); chk(rd2(1));

    // Four read ports with independent slices.
    step();
    b4.WE0 = 1'b1; b4.A0 = 5'd1; b4.WD0 = 32'h11;
    b4.WE1 = 1'b1; b4.A1 = 5'd2; b4.WD1 = 32'h22;
    step();
    b4.WE1 = 1'b0;
    b4.A0 = 5'd3; b4.WD0 = 32'h33;
    step();
    b4.WE0 = 1'b0;
    b4.A_RD = {5'd1, 5'd3, 5'd2, 5'd1};
    push("p4_rd0", 32'h11);
    push("p4_rd1", 32'h22);
    push("p4_rd2", 32'h33);
    push("p4_rd3", 32'h11);
    #1;
    for (int k = 0; k < 4; k++) chk(rd4(k));

    // Every queued expectation must have been consumed.
    total_cnt++;
    assert (exp_q.size() == 0) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL queue_drained: observed %0d left required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
